// File: rtl/spi_ram_pkg.sv
// Shared types and widths for the command-decoding RAM behind the SPI slave.
package spi_ram_pkg;

  localparam int unsigned CMD_W  = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = CMD_W + DATA_W;

  // Command field of a received SPI word (din[9:8]).
  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // Read-data hold machine: HOLD keeps tx_valid up while the slave shifts a byte out.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port storage array: synchronous write, registered read on enable, no reset.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write and read-data capture; read data stays frozen until the next enable.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram.sv
// Command decoder, address/flag registers and tx hold timer in front of spi_ram_mem.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned TX_HOLD   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              cmd_err
);

  localparam int unsigned CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

  cmd_e                 cmd_c;
  logic [ADDR_SIZE-1:0] addr_c;
  logic [DATA_W-1:0]    data_c;

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_ok_q, wr_ok_d;
  logic                 rd_ok_q, rd_ok_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 dout_vld_q, dout_vld_d;
  hold_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 mem_we;
  logic                 mem_re;
  logic                 rd_start;
  logic [DATA_W-1:0]    mem_rdata;

  assign cmd_c  = cmd_e'(din[WORD_W-1:DATA_W]);
  assign addr_c = din[ADDR_SIZE-1:0];
  assign data_c = din[DATA_W-1:0];

  // Command decode: one command per rx_valid cycle, illegal sequences flag an error.
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_ok_d    = wr_ok_q;
    rd_ok_d    = rd_ok_q;
    dout_vld_d = dout_vld_q;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    rd_start   = 1'b0;
    if (rx_valid) begin
      unique case (cmd_c)
        CMD_WR_ADDR: begin
          wr_addr_d = addr_c;
          wr_ok_d   = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_ok_q) begin
            mem_we    = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d = addr_c;
          rd_ok_d   = 1'b1;
        end
        CMD_RD_DATA: begin
          // A read is only taken while no byte is being held for the slave.
          if (rd_ok_q && (state_q == ST_IDLE)) begin
            mem_re     = 1'b1;
            rd_start   = 1'b1;
            dout_vld_d = 1'b1;
            rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Hold machine next state: count TX_HOLD cycles of tx_valid per accepted read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(TX_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address, flag and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
      dout_vld_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ok_q    <= wr_ok_d;
      rd_ok_q    <= rd_ok_d;
      cmd_err_q  <= cmd_err_d;
      dout_vld_q <= dout_vld_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  spi_ram_mem #(
    .ADDR_W (ADDR_SIZE),
    .DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (data_c),
    .re_i    (mem_re),
    .raddr_i (rd_addr_q),
    .rdata_o (mem_rdata)
  );

  // The un-reset read register is masked to zero until a read has landed since reset.
  assign dout     = dout_vld_q ? mem_rdata : '0;
  assign tx_valid = (state_q == ST_HOLD);
  assign cmd_err  = cmd_err_q;

endmodule

// File: doc/spi_ram.md
# spi_ram

- Command-decoding single-port RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit `rx_data`/`rx_valid` words: bits [9:8] are the command, bits [7:0] are the payload.
- Returns read data on `dout`/`tx_valid`, which the slave serializes onto MISO.
- Holds `tx_valid` for the full byte-serialization window and flags illegal command sequences.

## Interface
- `ADDR_SIZE`, default 8: address width; legal range 1..8.
- `MEM_DEPTH`, default 256: word count; must equal 2**ADDR_SIZE.
- `TX_HOLD`, default 8: cycles that `tx_valid`/`dout` are held per read; must be ≥1.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `din`, in, 10: command word from the SPI slave.
- `rx_valid`, in, 1: `din` is valid this cycle; each high cycle is one command.
- `dout`, out, 8: read data toward the SPI slave.
- `tx_valid`, out, 1: `dout` is valid; high for exactly TX_HOLD cycles per accepted read.
- `cmd_err`, out, 1: one-cycle pulse on a rejected command.

## Operation
- Commands are decoded only in cycles with `rx_valid`=1. `rx_valid`=0 means no state change except the hold countdown.
- Address payload is `din[ADDR_SIZE-1:0]`; the upper payload bits are ignored.
- `din[9:8]` decode:
  - 00 WR_ADDR: `wr_addr` ← payload; `wr_ok` ← 1.
  - 01 WR_DATA:
    - If `wr_ok`: `mem[wr_addr]` ← `din[7:0]`; `wr_addr` ← `wr_addr`+1.
    - Else: no write, `cmd_err` pulse.
  - 10 RD_ADDR: `rd_addr` ← payload; `rd_ok` ← 1.
  - 11 RD_DATA:
    - If `rd_ok` and not holding: `dout` ← `mem[rd_addr]`; `rd_addr` ← `rd_addr`+1; start hold.
    - Else: `cmd_err` pulse; `rd_addr` and `dout` unchanged.
- Address increments wrap modulo MEM_DEPTH (e.g. 255 → 0 at ADDR_SIZE=8). `wr_ok` and `rd_ok` stay set after a wrap.
- Hold FSM, states IDLE and HOLD:
  - IDLE → HOLD on an accepted RD_DATA; the counter loads TX_HOLD-1.
  - HOLD decrements each cycle and returns to IDLE on the cycle its count is 0.
  - `tx_valid` = (state==HOLD).
  - WR_ADDR, WR_DATA and RD_ADDR are accepted normally during HOLD. `dout` is frozen throughout HOLD.
- Write then read of the same address returns the newly written value. Only one command exists per cycle, so there is no same-cycle conflict.
- Reset values:
  - `dout`=0, `tx_valid`=0, `cmd_err`=0.
  - `wr_addr`=0, `rd_addr`=0, `wr_ok`=0, `rd_ok`=0; FSM in IDLE.
  - Memory array is not reset; contents persist across `rst`.

## Timing
- Write latency: `mem` is updated at the same rising edge that samples WR_DATA.
- Read latency 1:
  - RD_DATA sampled at edge N.
  - `dout` and `tx_valid` are valid after edge N (cycles N+1..N+TX_HOLD).
  - `tx_valid` is low after edge N+TX_HOLD.
- `dout` retains its last value after the hold ends.
- `cmd_err` is registered: high for exactly the one cycle after the offending edge.
- RD_DATA sampled in the last HOLD cycle (count 0) is rejected. A new read may be accepted at the first edge where the state is IDLE.
- Back-to-back accepted reads are therefore spaced by ≥TX_HOLD+1 cycles in `rx_valid` terms.
- `rst` assertion mid-hold forces `tx_valid`=0 and `cmd_err`=0 immediately, without waiting for a clock edge. On release, the FSM starts in IDLE.

## Structure
- Package `spi_ram_pkg`:
  - Command encodings `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`.
  - The hold-FSM state type.
  - `CMD_W`=2, `DATA_W`=8, `WORD_W`=10. `WORD_W` is shared with the SPI slave.
- Sub-module `spi_ram_mem`: MEM_DEPTH×8 array with synchronous write and synchronous read-enable. It has no reset.
- Top level `spi_ram`: decode, address and flag registers, hold FSM/counter, error pulse.

## Test plan
- Reset, then WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA:
  - `dout`=0xA5 with `tx_valid` high for exactly 8 cycles starting the cycle after RD_DATA.
  - `cmd_err` never asserted.
- Auto-increment wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, then read from 0xFF twice:
  - Reads return 0x11 and then `mem[0x00]`=0x22.
- After reset, WR_DATA 0x33 with no prior WR_ADDR → `cmd_err` one-cycle pulse and no memory change. RD_DATA before RD_ADDR → `cmd_err`, `tx_valid` stays 0.
- Issue RD_DATA on cycle 3 of a hold → `cmd_err` pulse, `dout` and `rd_addr` unchanged. WR_DATA issued mid-hold still writes.
- Assert `rst` at hold cycle 4 → `tx_valid`=0 immediately. After release, RD_ADDR/RD_DATA on the pre-reset address returns the pre-reset data.
- TX_HOLD=1 variant: consecutive accepted reads spaced 2 cycles apart each produce a single-cycle `tx_valid`.
